// File: rtl/clb_module_if.sv
// Programming and logic-evaluation signals of one configurable logic block.
// master = whatever feeds the CLB (chain/fabric), slave = the CLB itself.
interface clb_module_if;
  logic       prog_en;
  logic       prog_in;
  logic [3:0] clb_input;
  logic       prog_out;
  logic       clb_output;

  modport master (
    output prog_en,
    output prog_in,
    output clb_input,
    input  prog_out,
    input  clb_output
  );

  modport slave (
    input  prog_en,
    input  prog_in,
    input  clb_input,
    output prog_out,
    output clb_output
  );
endinterface

// File: rtl/clb_module.sv
// Configurable logic block: 17-bit serial config chain (mode bit + 16-entry LUT4)
// with a selectable combinational or registered output.
module clb_module (
  input  logic        clb_clk,
  input  logic        rst_n,
  input  logic        prog_clk,
  clb_module_if.slave bus
);

  logic [16:0] cfg;
  logic [15:0] lut;
  logic        lut_val;
  logic        out_q;
  logic        unused_prog_clk;

  // prog_clk is a legacy pin only; all programming runs on clb_clk.
  assign unused_prog_clk = prog_clk;

  // Shift LSB first: new bit enters at the top, cfg[0] leaves via prog_out.
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (bus.prog_en) begin
      cfg <= {bus.prog_in, cfg[16:1]};
    end
  end

  assign lut     = cfg[16:1];
  assign lut_val = lut[bus.clb_input];

  // Loads every edge so a mode switch to registered has valid data at once.
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= lut_val;
    end
  end

  assign bus.prog_out   = cfg[0];
  assign bus.clb_output = cfg[0] ? out_q : lut_val;

endmodule

// File: tb/tb_clb_module.sv
// Self-checking bench for clb_module: reset, LUT programming, registered mode,
// chain shift-out, reset during programming, overshift and hold behaviour.
module tb_clb_module;

  logic clb_clk  = 1'b0;
  logic rst_n    = 1'b0;
  logic prog_clk = 1'b0;

  clb_module_if bus ();

  clb_module dut (
    .clb_clk  (clb_clk),
    .rst_n    (rst_n),
    .prog_clk (prog_clk),
    .bus      (bus.slave)
  );

  always #5 clb_clk  = ~clb_clk;
  always #7 prog_clk = ~prog_clk;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  task automatic shift_bit(input logic b);
    @(negedge clb_clk);
    bus.prog_en = 1'b1;
    bus.prog_in = b;
    @(posedge clb_clk);
  endtask

  task automatic test_reset();
    logic e;
    rst_n         = 1'b0;
    bus.prog_en   = 1'b1;
    bus.prog_in   = 1'b1;
    bus.clb_input = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clb_clk);
      bus.clb_input = 4'($urandom_range(15));
      exp_q.push_back(1'b0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e) begin
        bad++;
        $display("FAIL reset_out cyc=%0d got=%b want=%b", i, bus.clb_output, e);
      end
      total++;
      if (bus.prog_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_prog_out cyc=%0d got=%b want=0", i, bus.prog_out);
      end
    end
    @(negedge clb_clk);
    bus.prog_en = 1'b0;
    #2 rst_n = 1'b1;
    // No shift may have happened while in reset: LUT must still be empty.
    for (int i = 0; i < 16; i++) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(i);
      exp_q.push_back(1'b0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e || bus.prog_out !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_empty in=%0d got=%b/%b want=%b/0", i, bus.clb_output, bus.prog_out, e);
      end
    end
  endtask

  task automatic test_comb_lut();
    logic [16:0] bs;
    logic        e;
    bs = 17'b11101110111011100;
    for (int k = 0; k < 17; k++) shift_bit(bs[k]);
    @(negedge clb_clk);
    bus.prog_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(i);
      exp_q.push_back((i % 4) != 0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e) begin
        bad++;
        $display("FAIL comb_lut in=%0d got=%b want=%b", i, bus.clb_output, e);
      end
      total++;
      if (bus.prog_out !== 1'b0) begin
        bad++;
        $display("FAIL comb_prog_out in=%0d got=%b want=0", i, bus.prog_out);
      end
    end
  endtask

  task automatic test_shift_out();
    logic [16:0] want_bits;
    logic        e;
    want_bits = 17'b11101110111011100;
    for (int k = 0; k < 17; k++) begin
      @(negedge clb_clk);
      bus.prog_en = 1'b1;
      bus.prog_in = 1'b0;
      #1;
      total++;
      if (bus.prog_out !== want_bits[k]) begin
        bad++;
        $display("FAIL shift_out edge=%0d got=%b want=%b", k, bus.prog_out, want_bits[k]);
      end
      @(posedge clb_clk);
    end
    @(negedge clb_clk);
    bus.prog_en = 1'b0;
    for (int i = 0; i < 16; i += 5) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(i);
      exp_q.push_back(1'b0);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e || bus.prog_out !== 1'b0) begin
        bad++;
        $display("FAIL cleared_cfg in=%0d got=%b/%b want=%b/0", i, bus.clb_output, bus.prog_out, e);
      end
    end
  endtask

  task automatic test_registered_and4();
    logic [16:0] bs;
    logic        e;
    logic        prev_exp;
    int          seq[10];
    bs  = {16'h8000, 1'b1};
    seq = '{0, 15, 15, 7, 15, 14, 11, 15, 0, 15};
    for (int k = 0; k < 17; k++) shift_bit(bs[k]);
    @(negedge clb_clk);
    bus.prog_en   = 1'b0;
    bus.clb_input = 4'd0;
    @(posedge clb_clk);
    prev_exp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(seq[i]);
      exp_q.push_back(seq[i] == 15);
      #1;
      total++;
      if (bus.clb_output !== prev_exp) begin
        bad++;
        $display("FAIL reg_before_edge step=%0d got=%b want=%b", i, bus.clb_output, prev_exp);
      end
      @(posedge clb_clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e) begin
        bad++;
        $display("FAIL reg_after_edge step=%0d in=%0d got=%b want=%b", i, seq[i], bus.clb_output, e);
      end
      prev_exp = e;
    end
  endtask

  task automatic test_reset_mid_prog();
    logic e;
    for (int k = 0; k < 9; k++) shift_bit(1'b1);
    @(negedge clb_clk);
    bus.prog_en   = 1'b0;
    bus.clb_input = 4'd15;
    #1;
    total++;
    if (bus.clb_output !== 1'b1) begin
      bad++;
      $display("FAIL partial_prog_lut got=%b want=1", bus.clb_output);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.clb_output !== 1'b0 || bus.prog_out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%b/%b want=0/0", bus.clb_output, bus.prog_out);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 17; k++) shift_bit(1'b1);
    @(negedge clb_clk);
    bus.prog_en = 1'b0;
    #1;
    total++;
    if (bus.prog_out !== 1'b1) begin
      bad++;
      $display("FAIL all_ones_mode got=%b want=1", bus.prog_out);
    end
    for (int i = 0; i < 16; i += 3) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(i);
      exp_q.push_back(1'b1);
      @(posedge clb_clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e) begin
        bad++;
        $display("FAIL all_ones_reg in=%0d got=%b want=%b", i, bus.clb_output, e);
      end
    end
  endtask

  task automatic test_overshift();
    logic [19:0] pv;
    logic        want;
    logic        e;
    pv = 20'h5A3C6;
    for (int k = 0; k < 20; k++) begin
      @(negedge clb_clk);
      bus.prog_en = 1'b1;
      bus.prog_in = pv[k];
      want = (k < 17) ? 1'b1 : pv[k-17];
      #1;
      total++;
      if (bus.prog_out !== want) begin
        bad++;
        $display("FAIL overshift_out edge=%0d got=%b want=%b", k, bus.prog_out, want);
      end
      @(posedge clb_clk);
    end
    @(negedge clb_clk);
    bus.prog_en = 1'b0;
    // Last 17 bits remain: cfg = pv[19:3], combinational mode, LUT[i] = pv[i+4].
    for (int i = 0; i < 16; i++) begin
      @(negedge clb_clk);
      bus.clb_input = 4'(i);
      exp_q.push_back(pv[i+4]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e) begin
        bad++;
        $display("FAIL overshift_lut in=%0d got=%b want=%b", i, bus.clb_output, e);
      end
    end
  endtask

  task automatic test_prog_hold();
    logic [19:0] pv;
    logic        e;
    int          idx;
    pv = 20'h5A3C6;
    for (int k = 0; k < 20; k++) begin
      @(negedge clb_clk);
      bus.prog_en   = 1'b0;
      bus.prog_in   = k[0];
      idx           = (k * 7) % 16;
      bus.clb_input = 4'(idx);
      exp_q.push_back(pv[idx+4]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (bus.clb_output !== e || bus.prog_out !== pv[3]) begin
        bad++;
        $display("FAIL prog_hold edge=%0d got=%b/%b want=%b/%b", k, bus.clb_output, bus.prog_out, e, pv[3]);
      end
      @(posedge clb_clk);
    end
  endtask

  initial begin
    bus.prog_en   = 1'b0;
    bus.prog_in   = 1'b0;
    bus.clb_input = 4'd0;
    test_reset();
    test_comb_lut();
    test_shift_out();
    test_registered_and4();
    test_reset_mid_prog();
    test_overshift();
    test_prog_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clb_module.md
CLB_MODULE -- requirements
Module: clb_module

Interface
REQ-001 clb_clk  input  1  sole clock; every flop samples on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 prog_clk  input  1  kept for pin compatibility; drives no logic, all programming is clocked by clb_clk.
REQ-004 prog_en  input  1  programming enable; high = configuration register shifts once per clb_clk edge.
REQ-005 prog_in  input  1  serial configuration data, sampled on clb_clk rising edge while prog_en=1.
REQ-006 clb_input  input  4  LUT address; clb_input[0]=x1, [1]=x2, [2]=x3, [3]=x4.
REQ-007 prog_out  output  1  serial chain output = cfg[0]; allows CLBs to be daisy-chained.
REQ-008 clb_output  output  1  logic-block result.

Function
REQ-009 The block SHALL hold a 17-bit configuration register cfg[16:0]: cfg[0] = output-mode bit, cfg[16:1] = LUT contents, LUT[i] = cfg[i+1].
REQ-010 With prog_en=1, each clb_clk rising edge SHALL perform cfg <= {prog_in, cfg[16:1]}; after 17 shifts with bitstream bit k presented on edge k (k=0..16, LSB first), cfg equals the bitstream.
REQ-011 With prog_en=0, cfg SHALL hold its value; prog_in ignored.
REQ-012 prog_out SHALL equal cfg[0] combinationally, i.e. the bit shifted out on the next programming edge.
REQ-013 lut_val SHALL be LUT[clb_input] = cfg[clb_input+1], combinational from clb_input and cfg.
REQ-014 cfg[0]=0 (combinational mode): clb_output SHALL equal lut_val with zero cycle latency.
REQ-015 cfg[0]=1 (registered mode): clb_output SHALL equal an output flop loaded with lut_val on every clb_clk rising edge (one-cycle latency).
REQ-016 The output flop SHALL load every clb_clk edge regardless of mode or prog_en.
REQ-017 LUT evaluation SHALL continue during programming, using the partially shifted cfg; no output gating.
REQ-018 A mode change (cfg[0] toggling) SHALL switch the clb_output source immediately, with no extra cycle.
REQ-019 Programming with more than 17 edges SHALL keep shifting; only the last 17 bits remain in cfg, older bits exit via prog_out in order.

Reset
REQ-020 rst_n=0 SHALL immediately clear cfg to 17'h0 and the output flop to 0, independent of clb_clk.
REQ-021 While in reset: prog_out=0, clb_output=0 (combinational mode, all-zero LUT).
REQ-022 Reset mid-programming SHALL discard all bits shifted so far; programming restarts from an empty register after rst_n returns high.
REQ-023 rst_n deassertion SHALL take effect at the next clb_clk rising edge; no shift occurs on an edge where rst_n=0.

Verification
REQ-024 Hold rst_n=0 with clb_clk toggling and prog_en=1, prog_in=1 -> clb_output=0, prog_out=0 throughout.
REQ-025 Shift 17'b11101110111011100 LSB first (17 edges, prog_en=1), then prog_en=0; sweep clb_input 0..15 -> clb_output 0,1,1,1 repeating (1 whenever clb_input[1:0]!=0), same cycle as input change; prog_out=0.
REQ-026 Shift {16'h8000,1'b1} (registered AND4) -> clb_input=15 gives clb_output=1 only after the next clb_clk edge; all other inputs give 0 one edge later.
REQ-027 After REQ-025 programming, shift 17 zeros -> prog_out on successive edges reproduces bits 0,0,1,1,1,0,1,1,1,0,1,1,1,0,1,1,1, then cfg=0.
REQ-028 Shift 9 ones, pulse rst_n low mid-cycle, then shift 17'h1FFFF -> cfg=17'h1FFFF exactly; registered mode, clb_output=1 for every input one edge later.
REQ-029 With cfg programmed, prog_en=0 and prog_in toggling for 20 edges -> cfg, prog_out, clb_output unchanged.
